// File: rtl/param_pkg.sv
// Shared D-cache widths, coherence state encodings and ACE snoop constants
// used by the snoop response controller.
package param_pkg;

    localparam int DCACHE_TAG_WIDTH   = 24;
    localparam int DCACHE_INDEX_WIDTH = 8;
    localparam int LINE_ADR_W         = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

    typedef enum logic [1:0] {
        TS_NONE = 2'd0,
        TS_IS   = 2'd1,
        TS_IM   = 2'd2,
        TS_MI   = 2'd3
    } transient_state_t;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2,
        ST_M = 2'd3
    } stable_state_t;

    localparam logic [3:0] SNP_READ_SHARED   = 4'h1;
    localparam logic [3:0] SNP_READ_UNIQUE   = 4'h7;
    localparam logic [3:0] SNP_CLEAN_INVALID = 4'h9;
    localparam logic [3:0] SNP_MAKE_INVALID  = 4'hD;

    // Bit positions inside the 5-bit CRRESP field
    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_DECIDE = 3'd2,
        S_STALL  = 3'd3,
        S_RESP   = 3'd4,
        S_DATA   = 3'd5
    } fsm_state_t;

endpackage

// File: rtl/snoop_resp_decode.sv
// Combinational snoop opcode x stable line state -> CRRESP, next stable
// state, whether the tag must be rewritten and whether line data follows.
module snoop_resp_decode
    import param_pkg::*;
(
    input  logic          [3:0] snoop_i,
    input  logic                tag_hit_i,
    input  stable_state_t       state_i,
    output logic          [4:0] resp_o,
    output stable_state_t       new_state_o,
    output logic                update_o,
    output logic                data_o
);

    logic is_unique;
    logic is_dirty;

    assign is_unique = (state_i == ST_M) || (state_i == ST_E);
    assign is_dirty  = (state_i == ST_M);

    always_comb begin
        resp_o      = '0;
        new_state_o = state_i;
        // A tag hit on an invalid way carries no ownership, so treat it as a miss
        if (tag_hit_i && (state_i != ST_I)) begin
            case (snoop_i)
                SNP_READ_SHARED: begin
                    resp_o[CR_WAS_UNIQUE]    = is_unique;
                    resp_o[CR_IS_SHARED]     = 1'b1;
                    resp_o[CR_PASS_DIRTY]    = is_dirty;
                    resp_o[CR_DATA_TRANSFER] = is_unique;
                    new_state_o              = ST_S;
                end
                SNP_READ_UNIQUE: begin
                    resp_o[CR_WAS_UNIQUE]    = is_unique;
                    resp_o[CR_PASS_DIRTY]    = is_dirty;
                    resp_o[CR_DATA_TRANSFER] = is_unique;
                    new_state_o              = ST_I;
                end
                SNP_CLEAN_INVALID: begin
                    resp_o[CR_WAS_UNIQUE]    = is_unique;
                    resp_o[CR_PASS_DIRTY]    = is_dirty;
                    resp_o[CR_DATA_TRANSFER] = is_dirty;
                    new_state_o              = ST_I;
                end
                SNP_MAKE_INVALID: begin
                    resp_o[CR_WAS_UNIQUE]    = is_unique;
                    new_state_o              = ST_I;
                end
                default: begin
                    new_state_o = state_i;
                end
            endcase
        end
        resp_o[CR_ERROR] = 1'b0;
    end

    assign update_o = (new_state_o != state_i);
    assign data_o   = resp_o[CR_DATA_TRANSFER];

endmodule

// File: rtl/snoop_resp_ctrl.sv
// ACE snoop responder: accepts one snoop, looks it up in the MSHR and tag
// array, updates the tag state, returns CRRESP and optionally the line data.
module snoop_resp_ctrl
    import param_pkg::*;
#(
    parameter int CD_W  = 64,
    parameter int BEATS = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ac_valid_i,
    output logic                         ac_ready_o,
    input  logic [LINE_ADR_W-1:0]        ac_addr_i,
    input  logic [3:0]                   ac_snoop_i,
    output logic                         cr_valid_o,
    input  logic                         cr_ready_i,
    output logic [4:0]                   cr_resp_o,
    output logic                         cd_valid_o,
    input  logic                         cd_ready_i,
    output logic [CD_W-1:0]              cd_data_o,
    output logic                         cd_last_o,
    output logic                         lk_req_o,
    output logic [LINE_ADR_W-1:0]        lk_adr_o,
    input  logic                         read_hit_i,
    input  transient_state_t             transient_state_i,
    input  logic                         tag_hit_i,
    input  logic [1:0]                   tag_state_i,
    output logic                         tag_we_o,
    output logic [1:0]                   tag_state_o,
    output logic                         data_req_o,
    output logic [$clog2(BEATS)-1:0]     data_beat_o,
    input  logic [CD_W-1:0]              data_i
);

    localparam int                BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    fsm_state_t             state_q,     state_d;
    logic [LINE_ADR_W-1:0]  addr_q,      addr_d;
    logic [3:0]             snoop_q,     snoop_d;
    logic [4:0]             resp_q,      resp_d;
    logic                   dt_q,        dt_d;
    logic [BEAT_W-1:0]      beat_q,      beat_d;
    logic                   rd_pend_q,   rd_pend_d;
    logic [CD_W-1:0]        cd_data_q,   cd_data_d;
    logic                   cd_valid_q,  cd_valid_d;
    logic                   cd_last_q,   cd_last_d;
    logic                   data_req_q,  data_req_d;
    logic                   ac_ready_q,  ac_ready_d;
    logic                   lk_req_q,    lk_req_d;
    logic                   cr_valid_q,  cr_valid_d;

    logic [4:0]             dec_resp;
    stable_state_t          dec_state;
    logic                   dec_update;
    logic                   dec_data;

    snoop_resp_decode u_decode (
        .snoop_i     (snoop_q),
        .tag_hit_i   (tag_hit_i),
        .state_i     (stable_state_t'(tag_state_i)),
        .resp_o      (dec_resp),
        .new_state_o (dec_state),
        .update_o    (dec_update),
        .data_o      (dec_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        resp_d      = resp_q;
        dt_d        = dt_q;
        beat_d      = beat_q;
        cd_data_d   = cd_data_q;
        cd_valid_d  = cd_valid_q;
        cd_last_d   = cd_last_q;
        data_req_d  = 1'b0;
        rd_pend_d   = data_req_q;
        tag_we_o    = 1'b0;
        tag_state_o = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (ac_valid_i && ac_ready_q) begin
                    addr_d  = ac_addr_i;
                    snoop_d = ac_snoop_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP, S_STALL: begin
                state_d = S_DECIDE;
            end
            // Lookup results are only valid here, so the tag write is driven
            // straight from them rather than through a register.
            S_DECIDE: begin
                if (read_hit_i && (transient_state_i == TS_MI)) begin
                    state_d = S_STALL;
                end else if (read_hit_i && ((transient_state_i == TS_IS) ||
                                            (transient_state_i == TS_IM))) begin
                    resp_d  = '0;
                    dt_d    = 1'b0;
                    state_d = S_RESP;
                end else begin
                    resp_d      = dec_resp;
                    dt_d        = dec_data;
                    tag_we_o    = dec_update;
                    tag_state_o = dec_update ? dec_state : ST_I;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (cr_ready_i) begin
                    if (dt_q) begin
                        state_d    = S_DATA;
                        beat_d     = '0;
                        data_req_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (rd_pend_q) begin
                    cd_data_d  = data_i;
                    cd_valid_d = 1'b1;
                    cd_last_d  = (beat_q == LAST_BEAT);
                end else if (cd_valid_q && cd_ready_i) begin
                    cd_valid_d = 1'b0;
                    cd_last_d  = 1'b0;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        data_req_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake strobes follow the state being entered
        ac_ready_d = (state_d == S_IDLE);
        lk_req_d   = (state_d == S_LOOKUP) || (state_d == S_STALL);
        cr_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            snoop_q    <= '0;
            resp_q     <= '0;
            dt_q       <= 1'b0;
            beat_q     <= '0;
            rd_pend_q  <= 1'b0;
            cd_data_q  <= '0;
            cd_valid_q <= 1'b0;
            cd_last_q  <= 1'b0;
            data_req_q <= 1'b0;
            ac_ready_q <= 1'b0;
            lk_req_q   <= 1'b0;
            cr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            snoop_q    <= snoop_d;
            resp_q     <= resp_d;
            dt_q       <= dt_d;
            beat_q     <= beat_d;
            rd_pend_q  <= rd_pend_d;
            cd_data_q  <= cd_data_d;
            cd_valid_q <= cd_valid_d;
            cd_last_q  <= cd_last_d;
            data_req_q <= data_req_d;
            ac_ready_q <= ac_ready_d;
            lk_req_q   <= lk_req_d;
            cr_valid_q <= cr_valid_d;
        end
    end

    assign ac_ready_o  = ac_ready_q;
    assign cr_valid_o  = cr_valid_q;
    assign cr_resp_o   = resp_q;
    assign cd_valid_o  = cd_valid_q;
    assign cd_data_o   = cd_data_q;
    assign cd_last_o   = cd_last_q;
    assign lk_req_o    = lk_req_q;
    assign lk_adr_o    = addr_q;
    assign data_req_o  = data_req_q;
    assign data_beat_o = beat_q;

endmodule

// File: tb/tb_snoop_resp_ctrl.sv
// Randomised bench for snoop_resp_ctrl: cache/MSHR responder plus a
// table-driven reference of the snoop coherence rules.
module tb_snoop_resp_ctrl;
    import param_pkg::*;

    localparam int CD_W   = 64;
    localparam int BEATS  = 4;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int AW     = LINE_ADR_W;

    logic                clk = 1'b0;
    logic                resetn;
    logic                ac_valid_i, ac_ready_o;
    logic [AW-1:0]       ac_addr_i;
    logic [3:0]          ac_snoop_i;
    logic                cr_valid_o, cr_ready_i;
    logic [4:0]          cr_resp_o;
    logic                cd_valid_o, cd_ready_i, cd_last_o;
    logic [CD_W-1:0]     cd_data_o;
    logic                lk_req_o;
    logic [AW-1:0]       lk_adr_o;
    logic                read_hit_i;
    transient_state_t    transient_state_i;
    logic                tag_hit_i;
    logic [1:0]          tag_state_i;
    logic                tag_we_o;
    logic [1:0]          tag_state_o;
    logic                data_req_o;
    logic [BEAT_W-1:0]   data_beat_o;
    logic [CD_W-1:0]     data_i;

    snoop_resp_ctrl #(.CD_W(CD_W), .BEATS(BEATS)) dut (
        .clk(clk), .resetn(resetn),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
        .lk_req_o(lk_req_o), .lk_adr_o(lk_adr_o),
        .read_hit_i(read_hit_i), .transient_state_i(transient_state_i),
        .tag_hit_i(tag_hit_i), .tag_state_i(tag_state_i),
        .tag_we_o(tag_we_o), .tag_state_o(tag_state_o),
        .data_req_o(data_req_o), .data_beat_o(data_beat_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment configuration for the snoop in flight
    transient_state_t m_mode = TS_NONE;
    int               m_clear_cyc = 0;
    logic             m_tag_hit = 1'b0;
    logic [1:0]       m_tag_state = 2'd0;
    logic [CD_W-1:0]  line [BEATS];

    // Observations of one snoop
    bit              o_timeout;
    int              o_lk_cnt, o_lk_bad_adr, o_we_cnt, o_cr_early, o_cr_wait;
    int              o_resp_unstable, o_ac_busy, o_cd_unstable, o_last_cnt, o_last_idx;
    logic [1:0]      o_we_state;
    logic [4:0]      o_resp;
    logic            o_ac_ready_after;
    logic [CD_W-1:0] o_beats[$];

    // Tag/MSHR and data-array responder: results are presented one cycle
    // after the strobe, random junk at every other time.
    initial begin
        logic              prev_lk;
        logic              prev_req;
        logic [BEAT_W-1:0] prev_beat;
        prev_lk = 1'b0; prev_req = 1'b0; prev_beat = '0;
        forever begin
            @(negedge clk);
            if (prev_lk) begin
                read_hit_i        = (m_mode != TS_NONE) && (cyc < m_clear_cyc);
                transient_state_i = read_hit_i ? m_mode : TS_NONE;
                tag_hit_i         = m_tag_hit;
                tag_state_i       = m_tag_state;
            end else begin
                read_hit_i        = 1'($urandom_range(0, 1));
                transient_state_i = transient_state_t'($urandom_range(0, 3));
                tag_hit_i         = 1'($urandom_range(0, 1));
                tag_state_i       = 2'($urandom_range(0, 3));
            end
            data_i    = prev_req ? line[prev_beat] : CD_W'({$urandom, $urandom});
            prev_lk   = lk_req_o;
            prev_req  = data_req_o;
            prev_beat = data_beat_o;
        end
    end

    function automatic void model_snoop(input logic [3:0] op, input logic hit, input logic [1:0] st,
                                        input transient_state_t mode, output logic [4:0] resp,
                                        output logic we, output logic [1:0] nst);
        resp = 5'b0; nst = st; we = 1'b0;
        if (mode == TS_IS || mode == TS_IM || !hit || st == 2'd0) return;
        case (op)
            4'h1: begin
                nst = 2'd1;
                resp = (st == 2'd3) ? 5'b11101 : (st == 2'd2) ? 5'b11001 : 5'b01000;
            end
            4'h7: begin nst = 2'd0; resp = (st == 2'd3) ? 5'b10101 : (st == 2'd2) ? 5'b10001 : 5'b00000; end
            4'h9: begin nst = 2'd0; resp = (st == 2'd3) ? 5'b10101 : (st == 2'd2) ? 5'b10000 : 5'b00000; end
            4'hD: begin nst = 2'd0; resp = (st >= 2'd2) ? 5'b10000 : 5'b00000; end
            default: ;
        endcase
        we = (nst != st);
    endfunction

    task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] op, input logic hit,
                             input logic [1:0] st, input transient_state_t mode, input int clear_after,
                             input int cr_pct, input int cd_pct, input int cr_hold, input int stop_after);
        bit              accepted, done, pcd_valid, pcd_ready, resp_seen;
        logic [CD_W-1:0] pcd_data;
        accepted = 0; done = 0; pcd_valid = 0; pcd_ready = 0; resp_seen = 0; pcd_data = '0;
        m_mode = mode; m_tag_hit = hit; m_tag_state = st;
        for (int b = 0; b < BEATS; b++) line[b] = CD_W'({$urandom, $urandom});
        o_timeout = 0; o_lk_cnt = 0; o_lk_bad_adr = 0; o_we_cnt = 0; o_cr_early = 0; o_cr_wait = 0;
        o_resp_unstable = 0; o_ac_busy = 0; o_cd_unstable = 0; o_last_cnt = 0; o_last_idx = -1;
        o_we_state = 2'd0; o_resp = 5'b0; o_ac_ready_after = 1'b0; o_beats.delete();
        @(negedge clk);
        m_clear_cyc = cyc + clear_after;
        ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = op;
        for (int i = 0; i < 400 && !done; i++) begin
            #1;
            if (accepted) ac_valid_i = 1'b0;
            cr_ready_i = ($urandom_range(1, 100) <= cr_pct);
            if (cr_valid_o && o_cr_wait < cr_hold) cr_ready_i = 1'b0;
            cd_ready_i = ($urandom_range(1, 100) <= cd_pct);
            if (stop_after >= 0 && o_beats.size() == stop_after && cd_valid_o) begin
                cd_ready_i = 1'b0;
                break;
            end
            if (accepted && ac_ready_o) o_ac_busy++;
            if (lk_req_o) begin
                o_lk_cnt++;
                if (lk_adr_o !== addr) o_lk_bad_adr++;
            end
            if (tag_we_o === 1'b1) begin o_we_cnt++; o_we_state = tag_state_o; end
            if (cr_valid_o) begin
                if (mode == TS_MI && cyc < m_clear_cyc) o_cr_early++;
                if (resp_seen && cr_resp_o !== o_resp) o_resp_unstable++;
                o_resp = cr_resp_o; resp_seen = 1; o_cr_wait++;
                if (cr_ready_i && !cr_resp_o[0]) done = 1;
            end
            if (cd_valid_o && pcd_valid && !pcd_ready && cd_data_o !== pcd_data) o_cd_unstable++;
            if (cd_valid_o && cd_ready_i) begin
                o_beats.push_back(cd_data_o);
                if (cd_last_o) begin o_last_cnt++; o_last_idx = o_beats.size() - 1; done = 1; end
            end
            pcd_valid = cd_valid_o; pcd_ready = cd_ready_i; pcd_data = cd_data_o;
            if (ac_valid_i && ac_ready_o) accepted = 1;
            @(negedge clk);
        end
        if (stop_after < 0) begin
            if (!done) o_timeout = 1;
            #1;
            o_ac_ready_after = ac_ready_o;
            cr_ready_i = 1'b0; cd_ready_i = 1'b0; ac_valid_i = 1'b0;
            $display("snoop op=%h addr=%h hit=%0d st=%0d mshr=%0d resp=%b beats=%0d tag_we=%0d",
                     op, addr, hit, st, mode, o_resp, o_beats.size(), o_we_cnt);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; cr_ready_i = 0; cd_ready_i = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o, lk_req_o, lk_adr_o,
             tag_we_o, tag_state_o, data_req_o, data_beat_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got ac_ready=%b cr_valid=%b cd_valid=%b lk_req=%b expected all 0",
                               ac_ready_o, cr_valid_o, cd_valid_o, lk_req_o);
        end
        resetn = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (ac_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ac_ready: got %b expected 1", ac_ready_o); end
        $display("reset: done");
    endtask

    task automatic test_read_shared_m();
        run_snoop(32'h11111111, 4'h1, 1'b1, 2'd3, TS_NONE, 0, 100, 100, 0, -1);
        n_checks++; if (o_timeout) begin n_fail++; $display("FAIL rs_m_timeout: got 1 expected 0"); end
        n_checks++; if (o_resp !== 5'b11101) begin n_fail++; $display("FAIL rs_m_resp: got %b expected 11101", o_resp); end
        n_checks++; if (o_we_cnt !== 1 || o_we_state !== 2'd1) begin
            n_fail++; $display("FAIL rs_m_tag: got we=%0d state=%0d expected we=1 state=1", o_we_cnt, o_we_state); end
        n_checks++; if (o_lk_cnt !== 1 || o_lk_bad_adr !== 0) begin
            n_fail++; $display("FAIL rs_m_lookup: got cnt=%0d bad_adr=%0d expected 1/0", o_lk_cnt, o_lk_bad_adr); end
        n_checks++; if (o_beats.size() !== BEATS) begin n_fail++; $display("FAIL rs_m_beats: got %0d expected %0d", o_beats.size(), BEATS); end
        for (int b = 0; b < BEATS && b < o_beats.size(); b++) begin
            n_checks++; if (o_beats[b] !== line[b]) begin
                n_fail++; $display("FAIL rs_m_data%0d: got %h expected %h", b, o_beats[b], line[b]); end
        end
        n_checks++; if (o_last_cnt !== 1 || o_last_idx !== BEATS - 1) begin
            n_fail++; $display("FAIL rs_m_last: got cnt=%0d idx=%0d expected 1/%0d", o_last_cnt, o_last_idx, BEATS - 1); end
        n_checks++; if (o_ac_ready_after !== 1'b1) begin n_fail++; $display("FAIL rs_m_idle: got ac_ready=%b expected 1", o_ac_ready_after); end
    endtask

    task automatic test_stall_mi();
        run_snoop(32'h0ABC0123, 4'h7, 1'b1, 2'd3, TS_MI, 6, 100, 100, 0, -1);
        n_checks++; if (o_timeout) begin n_fail++; $display("FAIL mi_timeout: got 1 expected 0"); end
        n_checks++; if (o_cr_early !== 0) begin n_fail++; $display("FAIL mi_cr_early: got %0d cycles expected 0", o_cr_early); end
        n_checks++; if (o_lk_cnt < 2) begin n_fail++; $display("FAIL mi_reissue: got %0d lookups expected >=2", o_lk_cnt); end
        n_checks++; if (o_resp !== 5'b10101) begin n_fail++; $display("FAIL mi_resp: got %b expected 10101", o_resp); end
        n_checks++; if (o_we_cnt !== 1 || o_we_state !== 2'd0) begin
            n_fail++; $display("FAIL mi_tag: got we=%0d state=%0d expected we=1 state=0", o_we_cnt, o_we_state); end
        n_checks++; if (o_beats.size() !== BEATS) begin n_fail++; $display("FAIL mi_beats: got %0d expected %0d", o_beats.size(), BEATS); end
    endtask

    task automatic test_mshr_is();
        run_snoop(32'h00F0F0F0, 4'h9, 1'b1, 2'd3, TS_IS, 1 << 30, 100, 100, 0, -1);
        n_checks++; if (o_timeout) begin n_fail++; $display("FAIL is_timeout: got 1 expected 0"); end
        n_checks++; if (o_resp !== 5'b00000) begin n_fail++; $display("FAIL is_resp: got %b expected 00000", o_resp); end
        n_checks++; if (o_we_cnt !== 0) begin n_fail++; $display("FAIL is_tag_we: got %0d pulses expected 0", o_we_cnt); end
        n_checks++; if (o_beats.size() !== 0) begin n_fail++; $display("FAIL is_beats: got %0d expected 0", o_beats.size()); end
    endtask

    task automatic test_cd_backpressure();
        run_snoop(32'h12345678, 4'h1, 1'b1, 2'd2, TS_NONE, 0, 100, 50, 0, -1);
        n_checks++; if (o_resp !== 5'b11001) begin n_fail++; $display("FAIL bp_resp: got %b expected 11001", o_resp); end
        n_checks++; if (o_we_cnt !== 1 || o_we_state !== 2'd1) begin
            n_fail++; $display("FAIL bp_tag: got we=%0d state=%0d expected we=1 state=1", o_we_cnt, o_we_state); end
        n_checks++; if (o_cd_unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", o_cd_unstable); end
        n_checks++; if (o_beats.size() !== BEATS) begin n_fail++; $display("FAIL bp_beats: got %0d expected %0d", o_beats.size(), BEATS); end
        for (int b = 0; b < BEATS && b < o_beats.size(); b++) begin
            n_checks++; if (o_beats[b] !== line[b]) begin
                n_fail++; $display("FAIL bp_data%0d: got %h expected %h", b, o_beats[b], line[b]); end
        end
    endtask

    task automatic test_miss_cr_hold();
        run_snoop(32'h0000BEEF, 4'h1, 1'b0, 2'd3, TS_NONE, 0, 100, 100, 3, -1);
        n_checks++; if (o_resp !== 5'b00000) begin n_fail++; $display("FAIL miss_resp: got %b expected 00000", o_resp); end
        n_checks++; if (o_cr_wait !== 4 || o_resp_unstable !== 0) begin
            n_fail++; $display("FAIL miss_cr_hold: got valid_cycles=%0d changes=%0d expected 4/0", o_cr_wait, o_resp_unstable); end
        n_checks++; if (o_ac_busy !== 0) begin n_fail++; $display("FAIL miss_ac_busy: got %0d cycles expected 0", o_ac_busy); end
        n_checks++; if (o_we_cnt !== 0) begin n_fail++; $display("FAIL miss_tag_we: got %0d expected 0", o_we_cnt); end
    endtask

    task automatic test_reset_mid_data();
        run_snoop(32'h00C0FFEE, 4'h1, 1'b1, 2'd3, TS_NONE, 0, 100, 100, 0, 2);
        n_checks++; if (o_beats.size() !== 2 || !cd_valid_o) begin
            n_fail++; $display("FAIL mid_reach_beat2: got beats=%0d cd_valid=%b expected 2/1", o_beats.size(), cd_valid_o); end
        resetn = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o, lk_req_o, lk_adr_o,
             tag_we_o, tag_state_o, data_req_o, data_beat_o} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got cd_valid=%b cd_data=%h beat=%0d expected all 0",
                               cd_valid_o, cd_data_o, data_beat_o);
        end
        resetn = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (ac_ready_o !== 1'b1 || cd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: got ac_ready=%b cd_valid=%b expected 1/0", ac_ready_o, cd_valid_o); end
        $display("mid-data reset: done");
    endtask

    task automatic test_random();
        logic [3:0]       ops [6];
        logic [3:0]       op;
        logic             hit;
        logic [1:0]       st, exp_nst;
        logic [4:0]       exp_resp;
        logic             exp_we;
        transient_state_t mode;
        int               sel, clr;
        ops[0] = 4'h1; ops[1] = 4'h7; ops[2] = 4'h9; ops[3] = 4'hD; ops[4] = 4'h0; ops[5] = 4'hB;
        for (int t = 0; t < 40; t++) begin
            op  = ops[$urandom_range(0, 5)];
            hit = ($urandom_range(0, 4) != 0);
            st  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            mode = (sel < 6) ? TS_NONE : (sel == 6) ? TS_IS : (sel == 7) ? TS_IM : TS_MI;
            clr  = (mode == TS_MI) ? $urandom_range(1, 8) : (1 << 30);
            model_snoop(op, hit, st, mode, exp_resp, exp_we, exp_nst);
            run_snoop(AW'($urandom), op, hit, st, mode, clr, $urandom_range(30, 100), $urandom_range(30, 100), 0, -1);
            n_checks++; if (o_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout: got 1 expected 0", t); end
            n_checks++; if (o_resp !== exp_resp) begin n_fail++; $display("FAIL rnd%0d_resp: got %b expected %b", t, o_resp, exp_resp); end
            n_checks++; if (o_we_cnt !== int'(exp_we) || (exp_we && o_we_state !== exp_nst)) begin
                n_fail++; $display("FAIL rnd%0d_tag: got we=%0d state=%0d expected we=%0d state=%0d",
                                   t, o_we_cnt, o_we_state, exp_we, exp_nst); end
            n_checks++; if (o_beats.size() !== (exp_resp[0] ? BEATS : 0)) begin
                n_fail++; $display("FAIL rnd%0d_beats: got %0d expected %0d", t, o_beats.size(), exp_resp[0] ? BEATS : 0); end
            for (int b = 0; b < o_beats.size() && b < BEATS; b++) begin
                n_checks++; if (o_beats[b] !== line[b]) begin
                    n_fail++; $display("FAIL rnd%0d_data%0d: got %h expected %h", t, b, o_beats[b], line[b]); end
            end
            n_checks++; if (o_cd_unstable !== 0 || o_resp_unstable !== 0 || o_ac_busy !== 0 || o_lk_bad_adr !== 0) begin
                n_fail++; $display("FAIL rnd%0d_protocol: got cd_chg=%0d cr_chg=%0d ac_busy=%0d bad_adr=%0d expected 0",
                                   t, o_cd_unstable, o_resp_unstable, o_ac_busy, o_lk_bad_adr); end
        end
    endtask

    initial begin
        test_reset();
        test_read_shared_m();
        test_stall_mi();
        test_mshr_is();
        test_cd_backpressure();
        test_miss_cr_hold();
        test_reset_mid_data();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
